// File: rtl/driver_trace_buffer_reader.sv
// Trace buffer drain: reads BRAM entries in write order and streams them out in fixed bursts.
// Optional TRACE_RD_BEAT_CNT_EN adds a 32-bit accepted-beat counter output.
module driver_trace_buffer_reader #(
  parameter int TRACE_BUF_DATA_WIDTH = 256,
  parameter int TRACE_BUF_ADDR_WIDTH = 15,
  parameter int BRAM_RD_LATENCY      = 2,
  parameter int BURST_LEN            = 16
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            enable,
  input  logic                            wr_we,
  input  logic [TRACE_BUF_ADDR_WIDTH-1:0] wr_addr,
  input  logic                            resync,
  input  logic                            clear_overflow,
  output logic [TRACE_BUF_ADDR_WIDTH-1:0] bram_addrb,
  output logic                            bram_enb,
  input  logic [TRACE_BUF_DATA_WIDTH-1:0] bram_doutb,
  output logic [TRACE_BUF_DATA_WIDTH-1:0] m_tdata,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic                            m_tlast,
  output logic [TRACE_BUF_ADDR_WIDTH:0]   level,
  output logic                            overflow,
  output logic                            busy
`ifdef TRACE_RD_BEAT_CNT_EN
  ,
  output logic [31:0]                     beat_count
`endif
);

  localparam int DW         = TRACE_BUF_DATA_WIDTH;
  localparam int AW         = TRACE_BUF_ADDR_WIDTH;
  localparam int LAT        = BRAM_RD_LATENCY;
  localparam int FIFO_DEPTH = LAT + 2;
  localparam int FW         = $clog2(FIFO_DEPTH + 1);
  localparam int PW         = $clog2(FIFO_DEPTH);
  localparam int CW         = $clog2(2 * FIFO_DEPTH + 1);
  localparam int BW         = $clog2(BURST_LEN);

  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] rd_ptr;
  logic [LAT:1]  vld_q;
  logic [LAT:0]  vld_pipe;
  logic [CW-1:0] inflight;
  logic [CW-1:0] credit_used;
  logic          issue;
  logic          push;
  logic          pop;

  logic [DW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_idx;
  logic [PW-1:0] rd_idx;
  logic [FW-1:0] fifo_count;
  logic [BW-1:0] burst_cnt;

  // Stage 0 is the registered read strobe itself; stage LAT lines up with valid bram_doutb.
  assign vld_pipe = {vld_q, bram_enb};
  assign push     = vld_pipe[LAT];
  assign pop      = m_tvalid & m_tready;

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= LAT; i++)
      inflight = inflight + CW'(vld_pipe[i]);
  end

  // A beat leaving this cycle frees its slot, which keeps 1 read/cycle sustainable.
  assign credit_used = CW'(fifo_count) + inflight - CW'(pop);
  assign issue = (state == S_RUN) && enable && !resync && (level != '0) &&
                 (credit_used < CW'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (enable) state <= S_RUN;
        S_RUN:   if (!enable) state <= S_FLUSH;
        S_FLUSH: begin
          if (enable)
            state <= S_RUN;
          else if (inflight == '0 && fifo_count == '0)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bram_enb   <= 1'b0;
      bram_addrb <= '0;
      vld_q      <= '0;
    end else begin
      bram_enb <= issue;
      if (issue) bram_addrb <= rd_ptr;
      for (int i = 1; i <= LAT; i++)
        vld_q[i] <= vld_pipe[i-1];
    end
  end

  // Read pointer, unread level and overflow tracking.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (resync) begin
        rd_ptr <= wr_addr;
        level  <= wr_we ? (AW+1)'(1) : '0;
      end else begin
        if (issue || (wr_we && level == FULL))
          rd_ptr <= rd_ptr + 1'b1;
        case ({wr_we, issue})
          2'b10:   if (level != FULL) level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: ;
        endcase
      end
      if (wr_we && (level == FULL) && !issue && !resync)
        overflow <= 1'b1;
      else if (clear_overflow)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_idx] <= bram_doutb;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_idx     <= '0;
      rd_idx     <= '0;
      fifo_count <= '0;
      burst_cnt  <= '0;
    end else begin
      if (push) wr_idx <= (wr_idx == PW'(FIFO_DEPTH-1)) ? '0 : wr_idx + 1'b1;
      if (pop) begin
        rd_idx    <= (rd_idx == PW'(FIFO_DEPTH-1)) ? '0 : rd_idx + 1'b1;
        burst_cnt <= burst_cnt + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  assign m_tvalid = (fifo_count != '0);
  assign m_tdata  = m_tvalid ? fifo_mem[rd_idx] : '0;
  assign m_tlast  = m_tvalid && (burst_cnt == BW'(BURST_LEN-1));

`ifdef TRACE_RD_BEAT_CNT_EN
  always_ff @(posedge clk) begin
    if (!rstn)
      beat_count <= '0;
    else if (resync)
      beat_count <= pop ? 32'd1 : 32'd0;
    else if (pop)
      beat_count <= beat_count + 1'b1;
  end
`endif

endmodule
